// File: rtl/imm_gen_if.sv
// Request/response bundle for the immediate generator: decode-side request
// channel and register-read-side result channel, both valid/ready.
interface imm_gen_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [2:0]       in_imm_type;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   // Generator side.
   modport slave (
      input  in_valid, in_inst, in_imm_type, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, out_illegal
   );

   // Requester / consumer side.
   modport master (
      output in_valid, in_inst, in_imm_type, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, out_illegal
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator. Combinational decode on the input, then a
// two-entry buffer (OUT + SKID) so a registered in_ready still sustains one
// result per cycle. FIFO order; only flush or reset drop entries.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   imm_gen_if.slave   bus
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } entry_t;

   logic [31:0] inst;
   logic [63:0] dec64;
   logic        dec_ill;
   entry_t      new_ent;
   entry_t      out_q, out_d, skid_q, skid_d;
   logic        out_vld_q, out_vld_d;
   logic        skid_vld_q, skid_vld_d;
   logic        in_ready_q, in_ready_d;
   logic        accept, drain;
   logic        unused_bits;

   assign inst = bus.in_inst;

   // Decode at 64 bits and truncate, so sign extension is the same code for
   // both XLEN values (U at XLEN=64 gets bit 31 replicated for free).
   always_comb begin
      dec64   = '0;
      dec_ill = 1'b0;
      case (bus.in_imm_type)
         3'b000: dec64 = {{52{inst[31]}}, inst[31:20]};
         3'b001: dec64 = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         3'b010: dec64 = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         3'b011: dec64 = {{32{inst[31]}}, inst[31:12], 12'b0};
         3'b100: dec64 = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         3'b101: dec64 = {59'b0, inst[19:15]};
         3'b110: begin
            if (XLEN == 64) dec64 = {58'b0, inst[25:20]};
            else            dec64 = {59'b0, inst[24:20]};
         end
         default: begin
            dec64   = '0;
            dec_ill = 1'b1;
         end
      endcase
   end

   assign new_ent     = '{imm: dec64[XLEN-1:0], tag: bus.in_tag, illegal: dec_ill};
   // Opcode bits and the upper decode bits at XLEN=32 are intentionally dropped.
   assign unused_bits = ^{inst[6:0], dec64};

   assign accept = bus.in_valid && in_ready_q && !flush;
   assign drain  = out_vld_q && bus.out_ready;

   // Buffer steering: OUT refills from SKID first, new data lands behind it.
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (drain || !out_vld_q) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = accept;
            if (accept) skid_d = new_ent;
         end else if (accept) begin
            out_d     = new_ent;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = new_ent;
         skid_vld_d = 1'b1;
      end
      // Ready only while the overflow slot is free after this edge.
      in_ready_d = !skid_vld_d;
   end

   // State registers; in_ready held low during reset, high one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_vld_q;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_tag     = out_q.tag;
   assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance.
module tb_imm_gen_pipe;

   typedef struct {
      logic [63:0] imm;
      logic [3:0]  tag;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   total = 0;
   int   bad = 0;
   exp_t sbq [$];

   imm_gen_if #(.XLEN(32), .TAG_W(4)) a ();
   imm_gen_if #(.XLEN(64), .TAG_W(4)) b ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(a));
   imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b));

   always #5 clk = ~clk;

   task automatic test_reset();
      #2;
      total++;
      if ({a.out_valid, a.out_imm, a.out_tag, a.out_illegal, a.in_ready} !== '0) begin
         bad++;
         $display("FAIL reset_state: got v=%b imm=%h tag=%0d ill=%b rdy=%b want all 0",
                  a.out_valid, a.out_imm, a.out_tag, a.out_illegal, a.in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++;
      if (a.in_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge: got %b want 0", a.in_ready); end
      @(posedge clk); #1;
      total++;
      if (a.in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", a.in_ready); end
   endtask

   task automatic test_basic();
      exp_t e;
      a.out_ready = 1'b0;
      a.in_valid = 1'b1; a.in_inst = 32'hFFF00093; a.in_imm_type = 3'b000; a.in_tag = 4'd3;
      @(negedge clk);
      total++;
      if (a.in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", a.in_ready); end
      sbq.push_back(exp_t'{64'hFFFFFFFFFFFFFFFF, 4'd3, 1'b0});
      @(posedge clk); #1;
      a.in_valid = 1'b0;
      e = sbq.pop_front();
      total++;
      if ({a.out_valid, a.out_imm, a.out_tag, a.out_illegal} !== {1'b1, e.imm[31:0], e.tag, e.ill}) begin
         bad++;
         $display("FAIL basic_latency: got v=%b imm=%h tag=%0d ill=%b want v=1 imm=%h tag=%0d ill=%b",
                  a.out_valid, a.out_imm, a.out_tag, a.out_illegal, e.imm[31:0], e.tag, e.ill);
      end
      a.out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if (a.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got v=%b want 0", a.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] insts [3];
      logic [2:0]  types [3];
      logic [63:0] imms [3];
      int got_cyc [3];
      int sent = 0, got = 0, cyc = 0;
      exp_t e;
      insts = '{32'hFE000EE3, 32'hFE002C23, 32'h0020006F};
      types = '{3'b010, 3'b001, 3'b100};
      imms  = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h2};
      got_cyc = '{0, 0, 0};
      a.out_ready = 1'b1;
      while ((sent < 3 || got < 3) && cyc < 40) begin
         if (sent < 3) begin
            a.in_valid = 1'b1; a.in_inst = insts[sent]; a.in_imm_type = types[sent]; a.in_tag = 4'(sent + 10);
         end else a.in_valid = 1'b0;
         @(negedge clk);
         if (a.out_valid && a.out_ready) begin
            total++;
            if (sbq.size() == 0) begin bad++; $display("FAIL b2b_extra: tag=%0d want none", a.out_tag); end
            else begin
               e = sbq.pop_front();
               if ({a.out_imm, a.out_tag, a.out_illegal} !== {e.imm[31:0], e.tag, e.ill}) begin
                  bad++;
                  $display("FAIL b2b_data: got imm=%h tag=%0d ill=%b want imm=%h tag=%0d ill=%b",
                           a.out_imm, a.out_tag, a.out_illegal, e.imm[31:0], e.tag, e.ill);
               end
            end
            if (got < 3) got_cyc[got] = cyc;
            got++;
         end
         if (a.in_valid && a.in_ready) begin
            sbq.push_back(exp_t'{imms[sent], 4'(sent + 10), 1'b0});
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      a.in_valid = 1'b0;
      total++;
      if (got != 3) begin bad++; $display("FAIL b2b_count: got %0d results want 3", got); end
      total++;
      if (got_cyc[2] - got_cyc[0] != 2) begin
         bad++; $display("FAIL b2b_spacing: got span %0d want 2", got_cyc[2] - got_cyc[0]);
      end
   endtask

   task automatic test_xlen64();
      logic [31:0] insts [4];
      logic [2:0]  types [4];
      logic [63:0] imms [4];
      int sent = 0, got = 0, cyc = 0;
      exp_t e;
      insts = '{32'h800000B7, 32'h123450B7, 32'h03F00093, 32'hFFF00093};
      types = '{3'b011, 3'b011, 3'b110, 3'b000};
      imms  = '{64'hFFFFFFFF80000000, 64'h0000000012345000, 64'h3F, 64'hFFFFFFFFFFFFFFFF};
      b.out_ready = 1'b1;
      while ((sent < 4 || got < 4) && cyc < 40) begin
         if (sent < 4) begin
            b.in_valid = 1'b1; b.in_inst = insts[sent]; b.in_imm_type = types[sent]; b.in_tag = 4'(sent);
         end else b.in_valid = 1'b0;
         @(negedge clk);
         if (b.out_valid && b.out_ready) begin
            total++;
            if (sbq.size() == 0) begin bad++; $display("FAIL x64_extra: tag=%0d want none", b.out_tag); end
            else begin
               e = sbq.pop_front();
               if ({b.out_imm, b.out_tag, b.out_illegal} !== {e.imm, e.tag, e.ill}) begin
                  bad++;
                  $display("FAIL x64_data: got imm=%h tag=%0d ill=%b want imm=%h tag=%0d ill=%b",
                           b.out_imm, b.out_tag, b.out_illegal, e.imm, e.tag, e.ill);
               end
            end
            got++;
         end
         if (b.in_valid && b.in_ready) begin
            sbq.push_back(exp_t'{imms[sent], 4'(sent), 1'b0});
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      b.in_valid = 1'b0;
      total++;
      if (got != 4) begin bad++; $display("FAIL x64_count: got %0d results want 4", got); end
   endtask

   task automatic test_formats32();
      logic [31:0] insts [3];
      logic [2:0]  types [3];
      exp_t        exps [3];
      int sent = 0, got = 0, cyc = 0;
      exp_t e;
      insts = '{32'hFFFFFFFF, 32'h000F8073, 32'h03F00093};
      types = '{3'b111, 3'b101, 3'b110};
      exps  = '{exp_t'{64'h0, 4'd9, 1'b1}, exp_t'{64'h1F, 4'd10, 1'b0}, exp_t'{64'h1F, 4'd11, 1'b0}};
      a.out_ready = 1'b1;
      while ((sent < 3 || got < 3) && cyc < 40) begin
         if (sent < 3) begin
            a.in_valid = 1'b1; a.in_inst = insts[sent]; a.in_imm_type = types[sent]; a.in_tag = exps[sent].tag;
         end else a.in_valid = 1'b0;
         @(negedge clk);
         if (a.out_valid && a.out_ready) begin
            total++;
            if (sbq.size() == 0) begin bad++; $display("FAIL fmt_extra: tag=%0d want none", a.out_tag); end
            else begin
               e = sbq.pop_front();
               if ({a.out_imm, a.out_tag, a.out_illegal} !== {e.imm[31:0], e.tag, e.ill}) begin
                  bad++;
                  $display("FAIL fmt_data: got imm=%h tag=%0d ill=%b want imm=%h tag=%0d ill=%b",
                           a.out_imm, a.out_tag, a.out_illegal, e.imm[31:0], e.tag, e.ill);
               end
            end
            got++;
         end
         if (a.in_valid && a.in_ready) begin
            sbq.push_back(exps[sent]);
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      a.in_valid = 1'b0;
      total++;
      if (got != 3) begin bad++; $display("FAIL fmt_count: got %0d results want 3", got); end
   endtask

   task automatic test_backpressure();
      int sent = 0, got = 0, cyc = 0;
      exp_t e;
      a.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         a.in_valid = 1'b1; a.in_inst = {12'(sent + 1), 20'h00093}; a.in_imm_type = 3'b000; a.in_tag = 4'(sent + 1);
         @(negedge clk);
         if (a.in_valid && a.in_ready) begin
            sbq.push_back(exp_t'{64'(sent + 1), 4'(sent + 1), 1'b0});
            sent++;
         end
         @(posedge clk); #1;
      end
      total++;
      if (sent != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", sent); end
      total++;
      if (a.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", a.in_ready); end
      total++;
      if ({a.out_valid, a.out_tag} !== {1'b1, 4'd1}) begin
         bad++; $display("FAIL bp_hold: got v=%b tag=%0d want v=1 tag=1", a.out_valid, a.out_tag);
      end
      a.out_ready = 1'b1;
      while ((sent < 3 || got < 3) && cyc < 40) begin
         if (sent < 3) begin
            a.in_valid = 1'b1; a.in_inst = {12'(sent + 1), 20'h00093}; a.in_tag = 4'(sent + 1);
         end else a.in_valid = 1'b0;
         @(negedge clk);
         if (a.out_valid && a.out_ready) begin
            total++;
            if (sbq.size() == 0) begin bad++; $display("FAIL bp_extra: tag=%0d want none", a.out_tag); end
            else begin
               e = sbq.pop_front();
               if ({a.out_imm, a.out_tag, a.out_illegal} !== {e.imm[31:0], e.tag, e.ill}) begin
                  bad++;
                  $display("FAIL bp_data: got imm=%h tag=%0d want imm=%h tag=%0d",
                           a.out_imm, a.out_tag, e.imm[31:0], e.tag);
               end
            end
            got++;
         end
         if (a.in_valid && a.in_ready) begin
            sbq.push_back(exp_t'{64'(sent + 1), 4'(sent + 1), 1'b0});
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      a.in_valid = 1'b0;
      total++;
      if (got != 3) begin bad++; $display("FAIL bp_count: got %0d results want 3", got); end
   endtask

   task automatic test_flush();
      a.out_ready = 1'b0;
      // Fill OUT and SKID.
      for (int c = 0; c < 2; c++) begin
         a.in_valid = 1'b1; a.in_inst = {12'(c + 5), 20'h00093}; a.in_imm_type = 3'b000; a.in_tag = 4'(c + 5);
         @(posedge clk); #1;
      end
      total++;
      if ({a.out_valid, a.in_ready} !== 2'b10) begin
         bad++; $display("FAIL flush_fill: got v=%b rdy=%b want v=1 rdy=0", a.out_valid, a.in_ready);
      end
      flush = 1'b1; a.in_inst = 32'h00700093; a.in_tag = 4'd7;
      @(posedge clk); #1;
      flush = 1'b0; a.in_valid = 1'b0;
      total++;
      if ({a.out_valid, a.in_ready} !== 2'b01) begin
         bad++; $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1", a.out_valid, a.in_ready);
      end
      // OUT full, SKID empty: the flush-cycle request would be accepted without flush.
      a.in_valid = 1'b1; a.in_inst = 32'h00800093; a.in_tag = 4'd8;
      @(posedge clk); #1;
      flush = 1'b1; a.in_inst = 32'h00900093; a.in_tag = 4'd9;
      @(posedge clk); #1;
      flush = 1'b0; a.in_valid = 1'b0;
      sbq.delete();
      total++;
      if ({a.out_valid, a.in_ready} !== 2'b01) begin
         bad++; $display("FAIL flush_half: got v=%b rdy=%b want v=0 rdy=1", a.out_valid, a.in_ready);
      end
      a.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (a.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_leak: got v=%b tag=%0d want v=0", a.out_valid, a.out_tag);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midstream();
      a.out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         a.in_valid = 1'b1; a.in_inst = 32'hFFF00093; a.in_imm_type = 3'b000; a.in_tag = 4'(c + 1);
         @(posedge clk); #1;
      end
      a.in_valid = 1'b0;
      total++;
      if (a.out_valid !== 1'b1) begin bad++; $display("FAIL rst_pre: got v=%b want 1", a.out_valid); end
      rst_n = 1'b0;
      #1;
      sbq.delete();
      total++;
      if ({a.out_valid, a.out_imm, a.out_tag, a.out_illegal, a.in_ready} !== '0) begin
         bad++;
         $display("FAIL rst_async: got v=%b imm=%h tag=%0d ill=%b rdy=%b want all 0",
                  a.out_valid, a.out_imm, a.out_tag, a.out_illegal, a.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      a.out_ready = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({a.in_ready, a.out_valid} !== 2'b10) begin
         bad++; $display("FAIL rst_release: got rdy=%b v=%b want rdy=1 v=0", a.in_ready, a.out_valid);
      end
   endtask

   initial begin
      a.in_valid = 1'b0; a.in_inst = '0; a.in_imm_type = '0; a.in_tag = '0; a.out_ready = 1'b0;
      b.in_valid = 1'b0; b.in_inst = '0; b.in_imm_type = '0; b.in_tag = '0; b.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_xlen64();
      test_formats32();
      test_backpressure();
      test_flush();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
